// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, lane alignment states and the
// 10b-to-8b data decode used by the receive lanes.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} tmds_align_state_t;

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  // Returns {valid, C1, C0}.
  function automatic logic [2:0] tmds_is_token(input logic [9:0] q);
    logic [2:0] r;
    case (q)
      TOKEN_C00: r = 3'b100;
      TOKEN_C01: r = 3'b101;
      TOKEN_C10: r = 3'b110;
      TOKEN_C11: r = 3'b111;
      default:   r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: bitslip-based word alignment on control-token runs,
// followed by a two-stage decode pipeline producing pixel data, DE and C1:C0.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned TOKEN_RUN      = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SLIP_WAIT      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] data_in,
  output logic       bitslip,
  output logic       aligned,
  output logic       video_de,
  output logic [1:0] video_ctrl,
  output logic [7:0] video_data
);

  localparam int unsigned TmoW  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned WaitW = $clog2(SLIP_WAIT + 1);
  localparam int unsigned RunW  = $clog2(TOKEN_RUN + 1);

  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(SEARCH_TIMEOUT - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);
  localparam logic [RunW-1:0]  RunMax   = RunW'(TOKEN_RUN);

  tmds_align_state_t state_q, state_d;

  logic [9:0]       data_q;
  logic             tok_q, tok_d;
  logic [1:0]       tok_c_q, tok_c_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             bitslip_q, bitslip_d;
  logic             aligned_q, aligned_d;
  logic             video_de_q, video_de_d;
  logic [1:0]       video_ctrl_q, video_ctrl_d;
  logic [7:0]       video_data_q, video_data_d;

  always_comb begin
    logic [2:0] tok_info;
    tok_info = tmds_is_token(data_in);
    tok_d    = tok_info[2];
    tok_c_d  = tok_info[1:0];
  end

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    wait_cnt_d = wait_cnt_q;

    if (!tok_q) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RunMax) begin
      run_cnt_d = run_cnt_q + RunW'(1);
    end else begin
      run_cnt_d = run_cnt_q;
    end

    unique case (state_q)
      SEARCH: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        // A completed run takes priority over a coincident timeout.
        if (run_cnt_q == RunMax) begin
          state_d   = LOCKED;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d   = SLIP;
          tmo_cnt_d = '0;
        end
      end
      SLIP: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
        run_cnt_d  = '0;
      end
      WAIT: begin
        run_cnt_d  = '0;
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (wait_cnt_q == WaitLast) begin
          state_d    = SEARCH;
          tmo_cnt_d  = '0;
          wait_cnt_d = '0;
        end
      end
      LOCKED: begin
        tmo_cnt_d = tok_q ? '0 : tmo_cnt_q + TmoW'(1);
        if (tmo_cnt_q == TmoLast) begin
          state_d   = SEARCH;
          tmo_cnt_d = '0;
          run_cnt_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    bitslip_d = (state_d == SLIP);
    aligned_d = (state_d == LOCKED);
    if (tok_q) begin
      video_de_d   = 1'b0;
      video_data_d = '0;
      video_ctrl_d = tok_c_q;
    end else begin
      video_de_d   = 1'b1;
      video_data_d = tmds_decode(data_q);
      video_ctrl_d = video_ctrl_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      data_q       <= '0;
      tok_q        <= 1'b0;
      tok_c_q      <= '0;
      run_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      video_de_q   <= 1'b0;
      video_ctrl_q <= '0;
      video_data_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_in;
      tok_q        <= tok_d;
      tok_c_q      <= tok_c_d;
      run_cnt_q    <= run_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      video_de_q   <= video_de_d;
      video_ctrl_q <= video_ctrl_d;
      video_data_q <= video_data_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign video_de   = video_de_q;
  assign video_ctrl = video_ctrl_q;
  assign video_data = video_data_q;

endmodule
